// File: rtl/xnor_serial_ctrl.sv
// xnor_serial_ctrl: sequencer for the serial-load wide XNOR datapath.
// Takes an activation/weight word pair, shifts it MSB-first onto dp_a/dp_w
// over WIDE cycles, waits DP_LAT cycles for the datapath to settle, then
// captures the datapath XNOR word and offers it on a valid/ready port.
// Optional feature macro: XNOR_CTRL_MAJ_EN adds the res_maj majority output.
module xnor_serial_ctrl #(
  parameter int WIDE   = 72,
  parameter int DP_LAT = 2,
  parameter int CNT_W  = $clog2(WIDE + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WIDE-1:0] in_act,
  input  logic [WIDE-1:0] in_wgt,
  output logic            dp_a,
  output logic            dp_w,
  input  logic [WIDE-1:0] dp_x,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [WIDE-1:0] res_x,
`ifdef XNOR_CTRL_MAJ_EN
  output logic            res_maj,
`endif
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(WIDE - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DP_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

`ifdef XNOR_CTRL_MAJ_EN
  localparam logic [CNT_W-1:0] HALF_W = CNT_W'(WIDE / 2);

  // Number of set bits in a datapath word; CNT_W bits hold values up to WIDE.
  function automatic logic [CNT_W-1:0] popcount(input logic [WIDE-1:0] v);
    logic [CNT_W-1:0] n;
    n = CNT_ZERO;
    for (int i = 0; i < WIDE; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  logic maj_q, maj_d;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Shadow words are kept pre-shifted so the next bit to send sits at the MSB.
  logic [WIDE-1:0]  act_sh_q, act_sh_d;
  logic [WIDE-1:0]  wgt_sh_q, wgt_sh_d;
  logic             dp_a_q, dp_a_d;
  logic             dp_w_q, dp_w_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDE-1:0]  res_x_q, res_x_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    act_sh_d    = act_sh_q;
    wgt_sh_d    = wgt_sh_q;
    dp_a_d      = 1'b0;
    dp_w_d      = 1'b0;
    res_valid_d = res_valid_q;
    res_x_d     = res_x_q;
`ifdef XNOR_CTRL_MAJ_EN
    maj_d       = maj_q;
`endif
    case (state_q)
      IDLE: begin
        res_valid_d = 1'b0;
        if (in_valid && in_ready_q) begin
          // Bit 0 of the job (the MSB) must already be on dp_a in the first SHIFT cycle.
          dp_a_d   = in_act[WIDE-1];
          dp_w_d   = in_wgt[WIDE-1];
          act_sh_d = {in_act[WIDE-2:0], 1'b0};
          wgt_sh_d = {in_wgt[WIDE-2:0], 1'b0};
          cnt_d    = CNT_ZERO;
          state_d  = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_q == SHIFT_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = DRAIN;
        end else begin
          dp_a_d   = act_sh_q[WIDE-1];
          dp_w_d   = wgt_sh_q[WIDE-1];
          act_sh_d = {act_sh_q[WIDE-2:0], 1'b0};
          wgt_sh_d = {wgt_sh_q[WIDE-2:0], 1'b0};
          cnt_d    = cnt_q + CNT_ONE;
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          res_x_d     = dp_x;
`ifdef XNOR_CTRL_MAJ_EN
          maj_d       = (popcount(dp_x) > HALF_W);
`endif
          res_valid_d = 1'b1;
          cnt_d       = CNT_ZERO;
          state_d     = OUT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          res_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = CNT_ZERO;
        res_valid_d = 1'b0;
      end
    endcase
    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == IDLE);
  end

  // State and registered outputs; reset abandons any job in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_ZERO;
      act_sh_q    <= {WIDE{1'b0}};
      wgt_sh_q    <= {WIDE{1'b0}};
      dp_a_q      <= 1'b0;
      dp_w_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_x_q     <= {WIDE{1'b0}};
      busy_q      <= 1'b0;
      // Held at 1 because the reset pin itself gates in_ready low during reset.
      in_ready_q  <= 1'b1;
`ifdef XNOR_CTRL_MAJ_EN
      maj_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_sh_q    <= act_sh_d;
      wgt_sh_q    <= wgt_sh_d;
      dp_a_q      <= dp_a_d;
      dp_w_q      <= dp_w_d;
      res_valid_q <= res_valid_d;
      res_x_q     <= res_x_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
`ifdef XNOR_CTRL_MAJ_EN
      maj_q       <= maj_d;
`endif
    end
  end

  // in_ready is low while reset is held and high from the first IDLE cycle after release.
  assign in_ready  = in_ready_q & reset;
  assign dp_a      = dp_a_q;
  assign dp_w      = dp_w_q;
  assign res_valid = res_valid_q;
  assign res_x     = res_x_q;
  assign busy      = busy_q;
`ifdef XNOR_CTRL_MAJ_EN
  assign res_maj   = maj_q;
`endif

endmodule

// File: tb/tb_xnor_serial_ctrl.sv
// Bench for xnor_serial_ctrl: a WIDE=8 instance for directed cases and a
// WIDE=72 instance for randomized jobs, each driving a behavioural model of
// the serial XNOR datapath. Outputs are predicted from the job timeline.
module tb_xnor_serial_ctrl;
  localparam int DP_LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic        rst_n    [2];
  logic        in_valid [2];
  logic [71:0] in_act   [2];
  logic [71:0] in_wgt   [2];
  logic        rr0    = 1'b1;
  logic        rr1    = 1'b1;
  logic        rnd_on = 1'b0;
  wire         res_ready [2];
  wire         o_rdy [2], o_dpa [2], o_dpw [2], o_rv [2], o_bsy [2];
  wire  [7:0]  rx_s;
  wire  [71:0] rx_l;
  wire  [71:0] o_rx [2];
  logic [71:0] sa [2], sw [2], dpx [2];
`ifdef XNOR_CTRL_MAJ_EN
  wire         o_maj [2];
`endif

  assign res_ready[0] = rr0;
  assign res_ready[1] = rr1;
  assign o_rx[0]      = {64'd0, rx_s};
  assign o_rx[1]      = rx_l;

  xnor_serial_ctrl #(.WIDE(8), .DP_LAT(DP_LAT)) u_small (
    .clk(clk), .reset(rst_n[0]), .in_valid(in_valid[0]), .in_ready(o_rdy[0]),
    .in_act(in_act[0][7:0]), .in_wgt(in_wgt[0][7:0]), .dp_a(o_dpa[0]), .dp_w(o_dpw[0]),
    .dp_x(dpx[0][7:0]), .res_valid(o_rv[0]), .res_ready(res_ready[0]), .res_x(rx_s),
`ifdef XNOR_CTRL_MAJ_EN
    .res_maj(o_maj[0]),
`endif
    .busy(o_bsy[0])
  );

  xnor_serial_ctrl #(.WIDE(72), .DP_LAT(DP_LAT)) u_large (
    .clk(clk), .reset(rst_n[1]), .in_valid(in_valid[1]), .in_ready(o_rdy[1]),
    .in_act(in_act[1]), .in_wgt(in_wgt[1]), .dp_a(o_dpa[1]), .dp_w(o_dpw[1]),
    .dp_x(dpx[1]), .res_valid(o_rv[1]), .res_ready(res_ready[1]), .res_x(rx_l),
`ifdef XNOR_CTRL_MAJ_EN
    .res_maj(o_maj[1]),
`endif
    .busy(o_bsy[1])
  );

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 72;
  endfunction

  function automatic logic [71:0] msk(input int i);
    logic [71:0] m;
    m = {72{1'b1}};
    if (i == 0) m = 72'hFF;
    return m;
  endfunction

  task automatic check(input int i, input string nm, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s dut%0d got %h expected %h at cycle %0d", nm, i, got, exp, cyc);
  endtask

  // Cycle counter used to timestamp accepts and results
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: two serial shift registers and a registered XNOR word
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      sa[i]  <= {sa[i][70:0], o_dpa[i]};
      sw[i]  <= {sw[i][70:0], o_dpw[i]};
      dpx[i] <= ~(sa[i] ^ sw[i]);
    end
  end

  // Random result backpressure for the wide instance
  always @(posedge clk) begin
    #1;
    rr1 = rnd_on ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Reference model state: job active flag and cycle index within the job
  bit          act_m [2];
  int          d_m [2];
  logic [71:0] a_m [2], w_m [2], res_m [2], seq_a [2], seq_w [2];
  bit          maj_m [2];
  int          n_acc [2], n_cons [2], last_acc [2], prev_acc [2], first_rv [2];
  int          vcnt [2], last_vcnt [2], rv_seen [2];
  logic [71:0] hs_log [$];

  // Predict all outputs from the job timeline and compare every cycle
  always @(negedge clk) begin
    int   w;
    logic e_rdy, e_bsy, e_rv, e_a, e_w;
    for (int i = 0; i < 2; i++) begin
      w = wid(i);
      e_a = 1'b0;
      e_w = 1'b0;
      if (!rst_n[i]) begin
        act_m[i] = 1'b0;
        res_m[i] = 72'd0;
        maj_m[i] = 1'b0;
        e_rdy = 1'b0; e_bsy = 1'b0; e_rv = 1'b0;
      end else begin
        if (act_m[i] && d_m[i] == w + DP_LAT + 1) begin
          res_m[i]    = ~(a_m[i] ^ w_m[i]) & msk(i);
          maj_m[i]    = ($countones(res_m[i]) > (w / 2));
          first_rv[i] = cyc;
        end
        e_rdy = !act_m[i];
        e_bsy = act_m[i];
        e_rv  = act_m[i] && (d_m[i] > w + DP_LAT);
        if (act_m[i] && d_m[i] >= 1 && d_m[i] <= w) begin
          e_a = a_m[i][w - d_m[i]];
          e_w = w_m[i][w - d_m[i]];
        end
      end
      check(i, "in_ready",  72'(o_rdy[i]), 72'(e_rdy));
      check(i, "busy",      72'(o_bsy[i]), 72'(e_bsy));
      check(i, "res_valid", 72'(o_rv[i]),  72'(e_rv));
      check(i, "dp_a",      72'(o_dpa[i]), 72'(e_a));
      check(i, "dp_w",      72'(o_dpw[i]), 72'(e_w));
      check(i, "res_x",     o_rx[i],       res_m[i]);
`ifdef XNOR_CTRL_MAJ_EN
      check(i, "res_maj",   72'(o_maj[i]), 72'(maj_m[i]));
`endif
      if (o_rv[i]) rv_seen[i]++;
      if (rst_n[i]) begin
        if (act_m[i] && d_m[i] >= 1 && d_m[i] <= w) begin
          seq_a[i] = {seq_a[i][70:0], o_dpa[i]};
          seq_w[i] = {seq_w[i][70:0], o_dpw[i]};
        end
        if (e_rv) vcnt[i]++;
        if (!act_m[i]) begin
          if (in_valid[i]) begin
            act_m[i]    = 1'b1;
            d_m[i]      = 1;
            a_m[i]      = in_act[i] & msk(i);
            w_m[i]      = in_wgt[i] & msk(i);
            n_acc[i]++;
            prev_acc[i] = last_acc[i];
            last_acc[i] = cyc;
            vcnt[i]     = 0;
            seq_a[i]    = 72'd0;
            seq_w[i]    = 72'd0;
          end
        end else if (e_rv && res_ready[i]) begin
          act_m[i]     = 1'b0;
          n_cons[i]++;
          last_vcnt[i] = vcnt[i];
          if (i == 0) hs_log.push_back(o_rx[0]);
        end else begin
          d_m[i]++;
        end
      end
    end
  end

  // Present a word pair until accepted; returns just after the accept edge
  task automatic send(input int i, input logic [71:0] a, input logic [71:0] w);
    bit ok;
    ok = 1'b0;
    in_act[i]   = a;
    in_wgt[i]   = w;
    in_valid[i] = 1'b1;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (o_rdy[i]) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid[i] = 1'b0;
    if (!ok) begin
      n_chk++;
      $display("FAIL accept_timeout dut%0d in_ready never seen at cycle %0d", i, cyc);
    end
  endtask

  // Wait until the instance reports idle, then step just past the next edge
  task automatic wait_idle(input int i);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 600 && !ok; n++) begin
      @(negedge clk);
      if (!o_bsy[i]) ok = 1'b1;
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL idle_timeout dut%0d busy stuck at cycle %0d", i, cyc);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    logic [95:0] ra, rw;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; in_valid[i] = 1'b0; in_act[i] = 72'd0; in_wgt[i] = 72'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(0, "rst_in_ready",  72'(o_rdy[0]), 72'd0);
    check(0, "rst_busy",      72'(o_bsy[0]), 72'd0);
    check(0, "rst_res_valid", 72'(o_rv[0]),  72'd0);
    check(0, "rst_res_x",     o_rx[0],       72'd0);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Reset pulled during SHIFT bit k=3
    send(0, 72'h5A, 72'hC3);
    repeat (3) @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    @(negedge clk);
    check(0, "midrst_res_valid", 72'(o_rv[0]),  72'd0);
    check(0, "midrst_busy",      72'(o_bsy[0]), 72'd0);
    check(0, "midrst_dp_a",      72'(o_dpa[0]), 72'd0);
    check(0, "midrst_dp_w",      72'(o_dpw[0]), 72'd0);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    @(negedge clk);
    check(0, "midrst_in_ready", 72'(o_rdy[0]), 72'd1);
    repeat (20) @(posedge clk);
    #1;
    check(0, "midrst_no_result", 72'(rv_seen[0]), 72'd0);

    // Basic job
    send(0, 72'hA5, 72'h0F);
    wait_idle(0);
    check(0, "basic_dp_a_seq", seq_a[0], 72'hA5);
    check(0, "basic_dp_w_seq", seq_w[0], 72'h0F);
    check(0, "basic_latency",  72'(first_rv[0] - last_acc[0]), 72'd11);
    check(0, "basic_valid_len", 72'(last_vcnt[0]), 72'd1);
    check(0, "basic_res", hs_log[hs_log.size() - 1], 72'h55);
`ifdef XNOR_CTRL_MAJ_EN
    check(0, "basic_maj", 72'(o_maj[0]), 72'd0);
`endif

    // Backpressure: 20 stalled cycles of res_valid before the handshake
    rr0 = 1'b0;
    send(0, 72'hFF, 72'hFF);
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (o_rv[0]) ok = 1'b1;
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL bp_valid_timeout dut0 res_valid never seen at cycle %0d", cyc);
    end
    repeat (20) @(posedge clk);
    #1;
    rr0 = 1'b1;
    wait_idle(0);
    check(0, "bp_valid_len", 72'(last_vcnt[0]), 72'd21);
    check(0, "bp_res", hs_log[hs_log.size() - 1], 72'hFF);
`ifdef XNOR_CTRL_MAJ_EN
    check(0, "bp_maj", 72'(o_maj[0]), 72'd1);
`endif

    // Back-to-back with in_valid held; second pair is offered during SHIFT
    send(0, 72'h00, 72'hFF);
    send(0, 72'h3C, 72'h3C);
    wait_idle(0);
    check(0, "b2b_first",   hs_log[hs_log.size() - 2], 72'h00);
    check(0, "b2b_second",  hs_log[hs_log.size() - 1], 72'hFF);
    check(0, "b2b_spacing", 72'(last_acc[0] - prev_acc[0]), 72'd12);

    // Randomized jobs on the wide instance with random result stalls
    rnd_on = 1'b1;
    for (int j = 0; j < 100; j++) begin
      ra = {$urandom(), $urandom(), $urandom()};
      rw = {$urandom(), $urandom(), $urandom()};
      send(1, ra[71:0], rw[71:0]);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rnd_on = 1'b0;
    wait_idle(1);
    check(1, "rnd_accepted", 72'(n_acc[1]),  72'd100);
    check(1, "rnd_returned", 72'(n_cons[1]), 72'd100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Hard stop in case the stimulus itself stalls
  initial begin
    #3000000;
    $display("FAIL global_timeout stimulus did not finish at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/xnor_serial_ctrl.md
Name: xnor_serial_ctrl

Overview:
Sequencer for the serial-load wide XNOR datapath, whose two WIDE-bit shift registers take one bit per clock and whose registered XNOR word is its output. Accepts a parallel activation/weight word pair over a valid/ready handshake and serialises it MSB-first onto the datapath's 1-bit a/w inputs for WIDE consecutive cycles. Waits out the datapath pipeline, captures the XNOR word, and presents it on a valid/ready result port. Sits between the window buffer and the majority/popcount stage.

Parameters:
WIDE, 72, bit width of activation/weight/result words; must match the datapath width; minimum 2
DP_LAT, 2, cycles from the last shifted bit's edge to a valid dp_x (shift-register settle + output register); minimum 1
CNT_W, $clog2(WIDE+1), width of the internal shift/wait counter; derived, not overridden

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous active-low reset
in_valid  input  1  word pair available
in_ready  output  1  controller can accept a word pair
in_act  input  WIDE  activation word
in_wgt  input  WIDE  weight word
dp_a  output  1  serial activation bit to datapath
dp_w  output  1  serial weight bit to datapath
dp_x  input  WIDE  registered XNOR word from datapath
res_valid  output  1  result held and valid
res_ready  input  1  downstream accepts result
res_x  output  WIDE  captured XNOR word
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, in_ready=0 during reset, dp_a=dp_w=0, res_valid=0, res_x=0, busy=0, shadow words=0. Reset asserted mid-operation abandons the job; no partial result is ever presented.
- States: IDLE, SHIFT, DRAIN, OUT.
- IDLE: in_ready=1. On in_valid&&in_ready at edge E0: latch in_act/in_wgt into shadow registers, counter=0, go to SHIFT.
- SHIFT: WIDE cycles, k=0..WIDE-1. dp_a=act_sh[WIDE-1-k], dp_w=wgt_sh[WIDE-1-k], both registered so bit k is stable for the whole cycle. After the last shift edge, the datapath shift registers equal the latched words exactly. Go to DRAIN with counter=0.
- DRAIN: DP_LAT cycles. dp_a=dp_w=0. At the edge ending the last DRAIN cycle, capture res_x<=dp_x and go to OUT.
- OUT: res_valid=1; res_x held stable. On res_valid&&res_ready go to IDLE, res_valid=0. res_x retains its last value until the next capture.
- Latency: with accept at edge E0, res_valid first samples high in cycle WIDE+DP_LAT+1 after E0 (WIDE=72, DP_LAT=2: cycle 75). If res_ready is already high, the result is consumed at that edge.
- Throughput: one job per WIDE+DP_LAT+2 cycles minimum. in_ready=0 outside IDLE. in_valid in other states is ignored; in_act/in_wgt may change freely after acceptance.
- dp_a/dp_w are 0 outside SHIFT. Garbage shifted into the datapath between jobs is harmless because every job pushes all WIDE bits.
- res_ready high while res_valid=0 has no effect. The counter never exceeds WIDE-1 in SHIFT or DP_LAT-1 in DRAIN.

Optional Feature:
Macro XNOR_CTRL_MAJ_EN.
- Defined: adds output res_maj (1 bit, reset 0), captured on the same edge as res_x. res_maj=1 iff popcount(dp_x) > WIDE/2 (integer division). The popcount is computed combinationally from dp_x in the last DRAIN cycle.
- Undefined: port and popcount logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-SHIFT: WIDE=8, accept a job, pull reset low at k=3 -> in the same cycle res_valid=0, busy=0, dp_a=dp_w=0; after release, in_ready=1 and no res_valid ever appears for the abandoned job.
- Basic job: WIDE=8, DP_LAT=2, in_act=8'hA5, in_wgt=8'h0F, res_ready=1 -> dp_a sequence 1,0,1,0,0,1,0,1; dp_w sequence 0,0,0,0,1,1,1,1; res_valid high for exactly one cycle, 11 cycles after accept; res_x=8'h55 (res_maj=0 with MAJ_EN).
- Backpressure: in_act=in_wgt=8'hFF, res_ready=0 for 20 cycles then 1 -> res_valid held high 21 cycles with res_x=8'hFF (res_maj=1) stable; in_ready=0 throughout; then IDLE.
- in_valid ignored while busy: second pair presented during SHIFT -> not accepted; it is accepted on the first IDLE cycle after the first result's handshake, and its result equals its own XNOR.
- Back-to-back jobs: 0x00/0xFF then 0x3C/0x3C with in_valid held high -> results 8'h00 then 8'hFF in order; accept-to-accept spacing is exactly 12 cycles.
- Default parameters: WIDE=72, random 100 jobs with random res_ready stalls -> every res_x equals ~(act^wgt) against a reference model; no lost or duplicated results.
